mc_decode: RTL

Control unit front end for the multicycle ARM datapath. It holds the main instruction-sequencing state machine and the ALU/PC decode. It produces the per-state enables (NextPC, RegW, MemW, IRWrite), mux selects, ALUControl, FlagW and PCS, which the condition logic stage consumes directly downstream. All strobes are Moore outputs of a registered state, plus a retired-instruction counter for bring-up.

---
 rtl/mc_pkg.sv | 47 ++++
 rtl/mc_decode_if.sv | 36 +++
 rtl/mainfsm.sv | 114 +++++++++++
 rtl/mc_decode.sv | 73 +++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states,
// datapath mux selects, ALU operation codes and the data-processing
// commands the ALU decoder recognises.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_t;

  localparam logic [1:0] SRCA_RN       = 2'b00;
  localparam logic [1:0] SRCA_PC       = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT   = 2'b10;

  localparam logic [1:0] SRCB_RM       = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALU_ADD       = 2'b00;
  localparam logic [1:0] ALU_SUB       = 2'b01;
  localparam logic [1:0] ALU_AND       = 2'b10;
  localparam logic [1:0] ALU_ORR       = 2'b11;

  localparam logic [3:0] CMD_ADD       = 4'b0100;
  localparam logic [3:0] CMD_SUB       = 4'b0010;
  localparam logic [3:0] CMD_AND       = 4'b0000;
  localparam logic [3:0] CMD_ORR       = 4'b1100;

  // The last state of every instruction; leaving it retires the instruction.
  function automatic logic is_retire(input state_t s);
    return s inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_UNKNOWN};
  endfunction

endpackage

// File: rtl/mc_decode_if.sv
// Bundle between the instruction register / datapath (master) and the
// control-unit front end (slave): instruction fields in, controls out.
interface mc_decode_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic [3:0]       Rd;
  logic             IRWrite;
  logic             AdrSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ResultSrc;
  logic [1:0]       ImmSrc;
  logic [1:0]       RegSrc;
  logic [1:0]       ALUControl;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             NextPC;
  logic             RegW;
  logic             MemW;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    output Op, Funct, Rd,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
           ALUControl, FlagW, PCS, NextPC, RegW, MemW, State, InstrCount
  );

  modport slave (
    input  Op, Funct, Rd,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
           ALUControl, FlagW, PCS, NextPC, RegW, MemW, State, InstrCount
  );
endinterface

// File: rtl/mainfsm.sv
// Instruction-sequencing state machine. All outputs are Moore decodes of
// the registered state; strobes are held low while reset is asserted so a
// mid-instruction reset cannot leave a partial write pulse.
module mainfsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_op,
  input  logic       i_funct_i,
  input  logic       i_funct_l,
  output state_t     o_state,
  output logic       o_irwrite,
  output logic       o_nextpc,
  output logic       o_regw,
  output logic       o_memw,
  output logic       o_adrsrc,
  output logic [1:0] o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_resultsrc,
  output logic       o_aluop,
  output logic       o_branch
);

  state_t r_state;
  state_t w_next;
  logic   w_irwrite, w_nextpc, w_regw, w_memw, w_branch;

  // State register; reset returns to FETCH without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state selection from the current state and the decoded fields.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (i_op)
          2'b00:   w_next = i_funct_i ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR: w_next = i_funct_l ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Per-state control decode; anything not named stays at zero.
  always_comb begin
    w_irwrite   = 1'b0;
    w_nextpc    = 1'b0;
    w_regw      = 1'b0;
    w_memw      = 1'b0;
    w_branch    = 1'b0;
    o_adrsrc    = 1'b0;
    o_aluop     = 1'b0;
    o_alusrca   = SRCA_RN;
    o_alusrcb   = SRCB_RM;
    o_resultsrc = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_nextpc    = 1'b1;
        o_alusrca   = SRCA_PC;
        o_alusrcb   = SRCB_FOUR;
        o_resultsrc = RES_ALURESULT;
      end
      S_DECODE: begin
        o_alusrca   = SRCA_PC;
        o_alusrcb   = SRCB_FOUR;
        o_resultsrc = RES_ALURESULT;
      end
      S_MEMADR: o_alusrcb = SRCB_EXTIMM;
      S_MEMRD:  o_adrsrc  = 1'b1;
      S_MEMWB: begin
        o_resultsrc = RES_DATA;
        w_regw      = 1'b1;
      end
      S_MEMWR: begin
        o_adrsrc = 1'b1;
        w_memw   = 1'b1;
      end
      S_EXECR:  o_aluop = 1'b1;
      S_EXECI: begin
        o_alusrcb = SRCB_EXTIMM;
        o_aluop   = 1'b1;
      end
      S_ALUWB:  w_regw = 1'b1;
      S_BRANCH: begin
        o_alusrca   = SRCA_ALUOUT;
        o_alusrcb   = SRCB_EXTIMM;
        o_resultsrc = RES_ALURESULT;
        w_branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_state   = r_state;
  assign o_irwrite = w_irwrite & reset;
  assign o_nextpc  = w_nextpc  & reset;
  assign o_regw    = w_regw    & reset;
  assign o_memw    = w_memw    & reset;
  assign o_branch  = w_branch  & reset;

endmodule

// File: rtl/mc_decode.sv
// Control-unit front end for the multicycle ARM datapath: main FSM plus
// ALU decode, PC-source detection and a retired-instruction counter.
module mc_decode
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  mc_decode_if.slave bus
);

  state_t           w_state;
  logic             w_regw, w_aluop, w_branch;
  logic [3:0]       w_cmd;
  logic [1:0]       w_alucontrol, w_flagw;
  logic [CNT_W-1:0] r_instr_count;

  assign w_cmd = bus.Funct[4:1];

  mainfsm u_mainfsm (
    .clk         (clk),
    .reset       (reset),
    .i_op        (bus.Op),
    .i_funct_i   (bus.Funct[5]),
    .i_funct_l   (bus.Funct[0]),
    .o_state     (w_state),
    .o_irwrite   (bus.IRWrite),
    .o_nextpc    (bus.NextPC),
    .o_regw      (w_regw),
    .o_memw      (bus.MemW),
    .o_adrsrc    (bus.AdrSrc),
    .o_alusrca   (bus.ALUSrcA),
    .o_alusrcb   (bus.ALUSrcB),
    .o_resultsrc (bus.ResultSrc),
    .o_aluop     (w_aluop),
    .o_branch    (w_branch)
  );

  // ALU operation and flag-write enables for data-processing execute states.
  always_comb begin
    w_alucontrol = ALU_ADD;
    w_flagw      = 2'b00;
    if (w_aluop) begin
      case (w_cmd)
        CMD_ADD: w_alucontrol = ALU_ADD;
        CMD_SUB: w_alucontrol = ALU_SUB;
        CMD_AND: w_alucontrol = ALU_AND;
        CMD_ORR: w_alucontrol = ALU_ORR;
        default: w_alucontrol = ALU_ADD;
      endcase
      // Only arithmetic ops update C/V; every S-suffixed op updates N/Z.
      w_flagw = {bus.Funct[0],
                 bus.Funct[0] & ((w_cmd == CMD_ADD) | (w_cmd == CMD_SUB))};
    end
  end

  // Count instructions as they leave their final state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_instr_count <= '0;
    else if (is_retire(w_state)) r_instr_count <= r_instr_count + CNT_W'(1);
  end

  assign bus.State      = w_state;
  assign bus.RegW       = w_regw;
  assign bus.ALUControl = w_alucontrol;
  assign bus.FlagW      = w_flagw;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.PCS        = ((bus.Rd == 4'hF) & w_regw) | w_branch;
  assign bus.InstrCount = r_instr_count;

endmodule
